fmt_link_arbiter: RTL and testbench
===================================

Name: fmt_link_arbiter

Overview:
Shares one downstream formatter link between two MCDF formatter outputs (m0, m1).
- Each port's req/chid/length is taken in and presented on the link one at a time.
- The downstream grant is forwarded back to the winning port only.
- The winner's packet (start..end) is muxed onto the link. Packets are never interleaved.
- Arbitration is round-robin per packet. Length and start-timeout violations are flagged.

Parameters:
START_TMO, 16, max cycles from forwarded grant to the winner's start before abort (1..255)
DATA_W, 32, link data width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
m0_req_i  in  1  port 0 formatter request
m0_chid_i  in  2  port 0 channel id, valid while m0_req_i
m0_length_i  in  6  port 0 packet length in words, valid while m0_req_i
m0_data_i  in  DATA_W  port 0 packet data
m0_start_i  in  1  port 0 first word
m0_end_i  in  1  port 0 last word
m0_grant_o  out  1  grant pulse to port 0
m1_req_i, m1_chid_i, m1_length_i, m1_data_i, m1_start_i, m1_end_i, m1_grant_o  as port 0, for port 1
lnk_grant_i  in  1  downstream grant pulse
lnk_req_o  out  1  downstream request
lnk_src_o  out  1  serving port index
lnk_chid_o  out  2  latched chid of serving port
lnk_length_o  out  6  latched length of serving port
lnk_data_o  out  DATA_W  muxed packet data
lnk_start_o  out  1  muxed start
lnk_end_o  out  1  muxed end
err_len_o  out  1  1-cycle pulse: word count != latched length at end
err_tmo_o  out  1  1-cycle pulse: start timeout abort
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rstn_i=0): state=IDLE, rr_last=1 (port 0 preferred first), all outputs 0, counters 0. Mid-packet reset drops the transfer; no error pulse.
- States: IDLE, REQ, WAIT_START, XFER.
- IDLE:
  - If any mX_req_i: pick a port. One requester wins. With both requesting, the port != rr_last wins.
  - Latch sel, chid, length. Go to REQ next cycle.
  - No requests: stay in IDLE.
- REQ:
  - lnk_req_o=1. lnk_src_o/chid/length come from the latched registers.
  - lnk_grant_i=1: go to WAIT_START. msel_grant_o=1 for exactly the next cycle (registered, 1-cycle latency). Clear timer.
  - msel_req_i=0 without grant: abort to IDLE, no error, rr_last unchanged. Grant in the same cycle wins over the withdrawal.
  - The non-selected port's req is ignored.
- WAIT_START:
  - lnk_req_o=0. Timer increments each cycle.
  - msel_start_i=1: word count=1 and go to XFER. If msel_end_i=1 in the same cycle (1-word packet): do the end check instead and go to IDLE.
  - Timer reaches START_TMO with no start: err_tmo_o pulse, go to IDLE, rr_last=sel.
- XFER: count+1 every cycle (formatter streams contiguously, one word per cycle).
- End of packet (msel_end_i=1): compare count (7-bit, saturating at 127) with latched length.
  - Mismatch: err_len_o pulse in the cycle after end.
  - Either way go to IDLE and set rr_last=sel.
  - A new pick happens in the IDLE cycle, so there is ≥1 idle cycle between lnk_end_o and the next lnk_req_o.
- Data mux:
  - In WAIT_START/XFER, lnk_data_o/start/end = selected port's inputs, combinational (0 latency).
  - In other states lnk_data_o=0 and start/end=0.
  - The non-selected port's start/end/data never reach the link.
- Length 0 is accepted. Any terminated packet then raises err_len_o.
- Grant pulses never go to a port that is not in service; m0_grant_o and m1_grant_o are never both 1.

Test Plan:
- Only m0 requests (chid=2, len=8), lnk_grant_i at cycle 3 → m0_grant_o 1-cycle pulse the next cycle; 8 words on link; lnk_src_o=0, lnk_chid_o=2, lnk_length_o=8; no errors; busy_o falls after end.
- m0 and m1 request continuously (len=4 each), downstream grants 2 cycles after each req → service order m0,m1,m0,m1; ≥1 idle cycle between packets; no interleaving.
- m1 len=16 but sends start..end over 15 words → err_len_o single pulse one cycle after end; next request is still served normally.
- Grant forwarded to m0, m0 never asserts start, START_TMO=16 → err_tmo_o pulse 16 cycles after the grant; next arbitration prefers m1.
- m0 withdraws req in REQ before lnk_grant_i → lnk_req_o drops, no grant, no error. Repeat with withdrawal coinciding with lnk_grant_i → grant honoured.
- rstn_i low mid-XFER (word 3 of 8) → all outputs 0 immediately, state IDLE; after release, m0 is preferred first.

Source files
------------

// File: rtl/fmt_link_arbiter_if.sv
// Bundle between the two formatter ports and the shared downstream link.
// The slave modport is the arbiter; the master modport is whatever drives it.
interface fmt_link_arbiter_if #(
  parameter int DATA_W = 32
);

  logic              m0_req_i;
  logic [1:0]        m0_chid_i;
  logic [5:0]        m0_length_i;
  logic [DATA_W-1:0] m0_data_i;
  logic              m0_start_i;
  logic              m0_end_i;
  logic              m0_grant_o;

  logic              m1_req_i;
  logic [1:0]        m1_chid_i;
  logic [5:0]        m1_length_i;
  logic [DATA_W-1:0] m1_data_i;
  logic              m1_start_i;
  logic              m1_end_i;
  logic              m1_grant_o;

  logic              lnk_grant_i;
  logic              lnk_req_o;
  logic              lnk_src_o;
  logic [1:0]        lnk_chid_o;
  logic [5:0]        lnk_length_o;
  logic [DATA_W-1:0] lnk_data_o;
  logic              lnk_start_o;
  logic              lnk_end_o;

  modport master (
    output m0_req_i, m0_chid_i, m0_length_i, m0_data_i, m0_start_i, m0_end_i,
    output m1_req_i, m1_chid_i, m1_length_i, m1_data_i, m1_start_i, m1_end_i,
    output lnk_grant_i,
    input  m0_grant_o, m1_grant_o,
    input  lnk_req_o, lnk_src_o, lnk_chid_o, lnk_length_o,
    input  lnk_data_o, lnk_start_o, lnk_end_o
  );

  modport slave (
    input  m0_req_i, m0_chid_i, m0_length_i, m0_data_i, m0_start_i, m0_end_i,
    input  m1_req_i, m1_chid_i, m1_length_i, m1_data_i, m1_start_i, m1_end_i,
    input  lnk_grant_i,
    output m0_grant_o, m1_grant_o,
    output lnk_req_o, lnk_src_o, lnk_chid_o, lnk_length_o,
    output lnk_data_o, lnk_start_o, lnk_end_o
  );

endinterface

// File: rtl/fmt_link_arbiter.sv
// Round-robin, per-packet arbiter sharing one downstream formatter link
// between two formatter ports, with length and start-timeout checking.
module fmt_link_arbiter #(
  parameter int START_TMO = 16,
  parameter int DATA_W    = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  fmt_link_arbiter_if.slave bus,
  output logic             err_len_o,
  output logic             err_tmo_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_START,
    XFER
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(START_TMO);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_rr_last;
  logic              r_sel;
  logic [1:0]        r_chid;
  logic [5:0]        r_length;
  logic [7:0]        r_timer;
  logic [6:0]        r_count;
  logic              r_grant0;
  logic              r_grant1;
  logic              r_err_len;
  logic              r_err_tmo;

  logic              w_pick;
  logic              w_sel_req;
  logic              w_sel_start;
  logic              w_sel_end;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_active;
  logic [7:0]        w_timer_inc;
  logic [6:0]        w_count_word;
  logic              w_len_bad;
  logic              w_latch;
  logic              w_grant_fwd;
  logic              w_end_chk;
  logic              w_tmo;

  // With both ports requesting, the one that was not served last wins.
  assign w_pick = (bus.m0_req_i && bus.m1_req_i) ? ~r_rr_last : bus.m1_req_i;

  assign w_sel_req   = r_sel ? bus.m1_req_i   : bus.m0_req_i;
  assign w_sel_start = r_sel ? bus.m1_start_i : bus.m0_start_i;
  assign w_sel_end   = r_sel ? bus.m1_end_i   : bus.m0_end_i;
  assign w_sel_data  = r_sel ? bus.m1_data_i  : bus.m0_data_i;

  assign w_active    = (r_state == WAIT_START) || (r_state == XFER);
  assign w_timer_inc = r_timer + 8'd1;

  // Word count including the current word; the start word is word 1.
  assign w_count_word = (r_state != XFER)   ? 7'd1 :
                        (r_count == 7'd127) ? r_count : r_count + 7'd1;
  assign w_len_bad    = (w_count_word != {1'b0, r_length});

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_grant_fwd  = 1'b0;
    w_end_chk    = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          w_latch      = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (bus.lnk_grant_i) begin
          w_grant_fwd  = 1'b1;
          w_state_next = WAIT_START;
        end else if (!w_sel_req) begin
          w_state_next = IDLE;
        end
      end
      WAIT_START: begin
        if (w_sel_start) begin
          if (w_sel_end) begin
            w_end_chk    = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_state_next = XFER;
          end
        end else if (w_timer_inc == TMO_LIMIT) begin
          w_tmo        = 1'b1;
          w_state_next = IDLE;
        end
      end
      XFER: begin
        if (w_sel_end) begin
          w_end_chk    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_sel     <= 1'b0;
      r_chid    <= 2'd0;
      r_length  <= 6'd0;
      r_timer   <= 8'd0;
      r_count   <= 7'd0;
      r_grant0  <= 1'b0;
      r_grant1  <= 1'b0;
      r_err_len <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_grant0  <= w_grant_fwd & ~r_sel;
      r_grant1  <= w_grant_fwd & r_sel;
      r_err_len <= w_end_chk & w_len_bad;
      r_err_tmo <= w_tmo;
      if (w_latch) begin
        r_sel    <= w_pick;
        r_chid   <= w_pick ? bus.m1_chid_i   : bus.m0_chid_i;
        r_length <= w_pick ? bus.m1_length_i : bus.m0_length_i;
      end
      if (w_grant_fwd) begin
        r_timer <= 8'd0;
      end else if (r_state == WAIT_START) begin
        r_timer <= w_timer_inc;
      end
      if (((r_state == WAIT_START) && w_sel_start) || (r_state == XFER)) begin
        r_count <= w_count_word;
      end
      if (w_end_chk || w_tmo) begin
        r_rr_last <= r_sel;
      end
    end
  end

  assign bus.m0_grant_o   = r_grant0;
  assign bus.m1_grant_o   = r_grant1;
  assign bus.lnk_req_o    = (r_state == REQ);
  assign bus.lnk_src_o    = busy_o & r_sel;
  assign bus.lnk_chid_o   = busy_o ? r_chid   : 2'd0;
  assign bus.lnk_length_o = busy_o ? r_length : 6'd0;
  assign bus.lnk_data_o   = w_active ? w_sel_data : '0;
  assign bus.lnk_start_o  = w_active & w_sel_start;
  assign bus.lnk_end_o    = w_active & w_sel_end;

  assign err_len_o = r_err_len;
  assign err_tmo_o = r_err_tmo;
  assign busy_o    = (r_state != IDLE);

endmodule

// File: tb/tb_fmt_link_arbiter.sv
// Directed bench for fmt_link_arbiter: single-port packets, round-robin
// alternation, length and timeout errors, request withdrawal and mid-packet reset.
module tb_fmt_link_arbiter;

  logic clk_i;
  logic rstn_i;
  logic err_len_o;
  logic err_tmo_o;
  logic busy_o;
  int   checks;
  int   errors;

  fmt_link_arbiter_if #(.DATA_W(32)) linkIf ();

  fmt_link_arbiter #(.START_TMO(16), .DATA_W(32)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .bus       (linkIf),
    .err_len_o (err_len_o),
    .err_tmo_o (err_tmo_o),
    .busy_o    (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req,
                               input logic [1:0] chid, input logic [5:0] len);
    if (port == 0) begin
      linkIf.m0_req_i    = req;
      linkIf.m0_chid_i   = chid;
      linkIf.m0_length_i = len;
    end else begin
      linkIf.m1_req_i    = req;
      linkIf.m1_chid_i   = chid;
      linkIf.m1_length_i = len;
    end
  endtask

  task automatic setWord(input int port, input logic s, input logic e,
                         input logic [31:0] d);
    if (port == 0) begin
      linkIf.m0_start_i = s;
      linkIf.m0_end_i   = e;
      linkIf.m0_data_i  = d;
    end else begin
      linkIf.m1_start_i = s;
      linkIf.m1_end_i   = e;
      linkIf.m1_data_i  = d;
    end
  endtask

  // Entered in a REQ cycle; returns in the first WAIT_START cycle.
  task automatic grantAfter(input int port, input int delay);
    for (int i = 0; i < delay; i++) begin
      settle();
      checkOutput("reqHeld", linkIf.lnk_req_o, 1);
      tick();
    end
    linkIf.lnk_grant_i = 1'b1;
    settle();
    checkOutput("reqAtGrant", linkIf.lnk_req_o, 1);
    tick();
    linkIf.lnk_grant_i = 1'b0;
    settle();
    checkOutput("grantToWinner", (port == 0) ? linkIf.m0_grant_o : linkIf.m1_grant_o, 1);
    checkOutput("noGrantToOther", (port == 0) ? linkIf.m1_grant_o : linkIf.m0_grant_o, 0);
    checkOutput("reqDropped", linkIf.lnk_req_o, 0);
  endtask

  // The idle port drives junk with start/end high; none of it may reach the link.
  task automatic streamWords(input int port, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      setWord(port, (i == 0), (i == n - 1), base + 32'(i));
      setWord(1 - port, 1'b1, 1'b1, 32'hDEAD0000 | 32'(i));
      settle();
      checkOutput("linkData", linkIf.lnk_data_o, base + 32'(i));
      checkOutput("linkStart", linkIf.lnk_start_o, (i == 0) ? 1 : 0);
      checkOutput("linkEnd", linkIf.lnk_end_o, (i == n - 1) ? 1 : 0);
      checkOutput("linkSrc", linkIf.lnk_src_o, 32'(port));
      tick();
    end
    setWord(0, 1'b0, 1'b0, 32'd0);
    setWord(1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn_i = 1'b1;
    linkIf.lnk_grant_i = 1'b0;
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    applyStimulus(1, 1'b0, 2'd0, 6'd0);
    setWord(0, 1'b0, 1'b0, 32'd0);
    setWord(1, 1'b0, 1'b0, 32'd0);
    #2 rstn_i = 1'b0;
    tick();
    tick();
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstLnkReq", linkIf.lnk_req_o, 0);
    checkOutput("rstGrant0", linkIf.m0_grant_o, 0);
    checkOutput("rstGrant1", linkIf.m1_grant_o, 0);
    checkOutput("rstErrLen", err_len_o, 0);
    checkOutput("rstErrTmo", err_tmo_o, 0);
    checkOutput("rstData", linkIf.lnk_data_o, 0);
    rstn_i = 1'b1;
    tick();

    // Single port: m0, chid 2, 8 words
    applyStimulus(0, 1'b1, 2'd2, 6'd8);
    settle();
    checkOutput("t1IdleBusy", busy_o, 0);
    tick();
    settle();
    checkOutput("t1LnkReq", linkIf.lnk_req_o, 1);
    checkOutput("t1Src", linkIf.lnk_src_o, 0);
    checkOutput("t1Chid", linkIf.lnk_chid_o, 2);
    checkOutput("t1Len", linkIf.lnk_length_o, 8);
    checkOutput("t1Busy", busy_o, 1);
    grantAfter(0, 2);
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    tick();
    settle();
    checkOutput("t1GrantPulseEnds", linkIf.m0_grant_o, 0);
    checkOutput("t1NoStartYet", linkIf.lnk_start_o, 0);
    streamWords(0, 8, 32'h000000A0);
    settle();
    checkOutput("t1ErrLen", err_len_o, 0);
    checkOutput("t1BusyFalls", busy_o, 0);

    // Length error: m1 declares 16, sends 15
    applyStimulus(1, 1'b1, 2'd1, 6'd16);
    tick();
    settle();
    checkOutput("t3Src", linkIf.lnk_src_o, 1);
    checkOutput("t3Chid", linkIf.lnk_chid_o, 1);
    checkOutput("t3Len", linkIf.lnk_length_o, 16);
    grantAfter(1, 0);
    applyStimulus(1, 1'b0, 2'd0, 6'd0);
    streamWords(1, 15, 32'h00000100);
    settle();
    checkOutput("t3ErrLenPulse", err_len_o, 1);
    tick();
    settle();
    checkOutput("t3ErrLenSingle", err_len_o, 0);

    // Both ports requesting continuously: m0, m1, m0, m1
    applyStimulus(0, 1'b1, 2'd0, 6'd4);
    applyStimulus(1, 1'b1, 2'd3, 6'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      settle();
      checkOutput("t2Src", linkIf.lnk_src_o, 32'(k % 2));
      checkOutput("t2Chid", linkIf.lnk_chid_o, (k % 2 == 1) ? 3 : 0);
      grantAfter(k % 2, 2);
      streamWords(k % 2, 4, 32'h00000200 + 32'(k) * 32'h100);
      settle();
      checkOutput("t2IdleGapBusy", busy_o, 0);
      checkOutput("t2IdleGapReq", linkIf.lnk_req_o, 0);
      checkOutput("t2ErrLen", err_len_o, 0);
    end
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    applyStimulus(1, 1'b0, 2'd0, 6'd0);
    tick();
    settle();
    checkOutput("t2StaysIdle", busy_o, 0);

    // Start timeout on m0
    applyStimulus(0, 1'b1, 2'd0, 6'd4);
    tick();
    grantAfter(0, 0);
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    checkOutput("t4NoTmoAtGrant", err_tmo_o, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      settle();
      checkOutput("t4NoTmoEarly", err_tmo_o, 0);
      checkOutput("t4WaitBusy", busy_o, 1);
    end
    tick();
    settle();
    checkOutput("t4TmoPulse", err_tmo_o, 1);
    checkOutput("t4TmoIdle", busy_o, 0);
    checkOutput("t4TmoNoLenErr", err_len_o, 0);
    applyStimulus(0, 1'b1, 2'd0, 6'd4);
    applyStimulus(1, 1'b1, 2'd2, 6'd2);
    tick();
    settle();
    checkOutput("t4TmoSingle", err_tmo_o, 0);
    checkOutput("t4PrefersM1", linkIf.lnk_src_o, 1);
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    grantAfter(1, 1);
    applyStimulus(1, 1'b0, 2'd0, 6'd0);
    streamWords(1, 2, 32'h00000600);
    settle();
    checkOutput("t4M1ErrLen", err_len_o, 0);

    // Withdrawal before grant, then withdrawal coinciding with grant
    applyStimulus(0, 1'b1, 2'd0, 6'd4);
    tick();
    settle();
    checkOutput("t5Req", linkIf.lnk_req_o, 1);
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    tick();
    settle();
    checkOutput("t5ReqDrops", linkIf.lnk_req_o, 0);
    checkOutput("t5AbortIdle", busy_o, 0);
    checkOutput("t5NoGrant", linkIf.m0_grant_o, 0);
    checkOutput("t5NoErrLen", err_len_o, 0);
    checkOutput("t5NoErrTmo", err_tmo_o, 0);
    applyStimulus(0, 1'b1, 2'd1, 6'd4);
    tick();
    settle();
    checkOutput("t5NoLateGrant", linkIf.m0_grant_o, 0);
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    linkIf.lnk_grant_i = 1'b1;
    tick();
    linkIf.lnk_grant_i = 1'b0;
    settle();
    checkOutput("t5GrantWins", linkIf.m0_grant_o, 1);
    checkOutput("t5GrantBusy", busy_o, 1);
    streamWords(0, 4, 32'h00000700);
    settle();
    checkOutput("t5ErrLen", err_len_o, 0);

    // Reset during word 3 of 8
    applyStimulus(0, 1'b1, 2'd3, 6'd8);
    tick();
    grantAfter(0, 0);
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    for (int i = 0; i < 2; i++) begin
      setWord(0, (i == 0), 1'b0, 32'h00000801 + 32'(i));
      tick();
    end
    setWord(0, 1'b0, 1'b0, 32'h00000803);
    settle();
    checkOutput("t6Word3", linkIf.lnk_data_o, 32'h00000803);
    rstn_i = 1'b0;
    settle();
    checkOutput("t6RstData", linkIf.lnk_data_o, 0);
    checkOutput("t6RstBusy", busy_o, 0);
    checkOutput("t6RstReq", linkIf.lnk_req_o, 0);
    checkOutput("t6RstChid", linkIf.lnk_chid_o, 0);
    checkOutput("t6RstLen", linkIf.lnk_length_o, 0);
    checkOutput("t6RstStart", linkIf.lnk_start_o, 0);
    setWord(0, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    rstn_i = 1'b1;
    applyStimulus(0, 1'b1, 2'd0, 6'd4);
    applyStimulus(1, 1'b1, 2'd1, 6'd4);
    settle();
    checkOutput("t6NoErrLen", err_len_o, 0);
    checkOutput("t6NoErrTmo", err_tmo_o, 0);
    tick();
    settle();
    checkOutput("t6ReqAfterRst", linkIf.lnk_req_o, 1);
    checkOutput("t6PrefersM0", linkIf.lnk_src_o, 0);
    applyStimulus(0, 1'b0, 2'd0, 6'd0);
    applyStimulus(1, 1'b0, 2'd0, 6'd0);
    tick();
    settle();
    checkOutput("t6WithdrawIdle", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
